// File: rtl/comandante_contador_pkg.sv
// Shared types and defaults for the counter commander.
package comandante_contador_pkg;

  localparam int LARGURA_PADRAO = 8;
  localparam int TIMEOUT_PADRAO = 4;

  typedef enum logic [2:0] {
    OCIOSO,
    AVALIA,
    PULSO,
    ESPERA,
    FIM,
    ERRO
  } estado_t;

  typedef enum logic {
    SOBE,
    DESCE
  } direcao_t;

endpackage

// File: rtl/comandante_contador_escolhe_direcao.sv
// Combinational choice of the shortest path from valor to the latched target.
module escolhe_direcao #(
  parameter int LARGURA = 8
) (
  input  logic [LARGURA-1:0] alvo_latched,
  input  logic [LARGURA-1:0] valor,
  output logic               igual,
  output logic               sobe
);

  // Half of the modular range; a distance of exactly half goes up.
  localparam logic [LARGURA-1:0] METADE = LARGURA'(1) << (LARGURA - 1);

  logic [LARGURA-1:0] diff;

  assign diff  = alvo_latched - valor;
  assign igual = (diff == '0);
  assign sobe  = (diff != '0) && (diff <= METADE);

endmodule

// File: rtl/comandante_contador.sv
// Drives an external up/down counter one step at a time until it reaches a target.
module comandante_contador
  import comandante_contador_pkg::*;
#(
  parameter int LARGURA = LARGURA_PADRAO,
  parameter int TIMEOUT = TIMEOUT_PADRAO
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LARGURA-1:0] alvo,
  input  logic               alvo_valido,
  output logic               pronto,
  input  logic [LARGURA-1:0] valor,
  output logic               acrescer,
  output logic               decrecer,
  output logic               concluido,
  output logic               erro
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] ULTIMO = CW'(TIMEOUT - 1);

  estado_t            estado;
  logic [LARGURA-1:0] alvo_reg;
  logic [LARGURA-1:0] esperado;
  logic [CW-1:0]      espera_cnt;
  logic               igual;
  logic               sobe;
  direcao_t           direcao;

  escolhe_direcao #(.LARGURA(LARGURA)) u_escolhe (
    .alvo_latched (alvo_reg),
    .valor        (valor),
    .igual        (igual),
    .sobe         (sobe)
  );

  assign direcao = sobe ? SOBE : DESCE;

  // FSM, wait counter and registered outputs; every output follows the state it enters.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado     <= OCIOSO;
      pronto     <= 1'b1;
      acrescer   <= 1'b0;
      decrecer   <= 1'b0;
      concluido  <= 1'b0;
      erro       <= 1'b0;
      alvo_reg   <= '0;
      esperado   <= '0;
      espera_cnt <= '0;
    end else begin
      // NOTE: state is updated with <= so every branch sees the pre-edge values;
      // pulse outputs default low here and are raised only on entry to their state.
      acrescer  <= 1'b0;
      decrecer  <= 1'b0;
      concluido <= 1'b0;
      erro      <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (alvo_valido) begin
            alvo_reg <= alvo;
            pronto   <= 1'b0;
            estado   <= AVALIA;
          end
        end
        AVALIA: begin
          if (igual) begin
            concluido <= 1'b1;
            estado    <= FIM;
          end else if (direcao == SOBE) begin
            esperado <= valor + 1'b1;
            acrescer <= 1'b1;
            estado   <= PULSO;
          end else begin
            esperado <= valor - 1'b1;
            decrecer <= 1'b1;
            estado   <= PULSO;
          end
        end
        PULSO: begin
          espera_cnt <= '0;
          estado     <= ESPERA;
        end
        ESPERA: begin
          if (valor == esperado) begin
            espera_cnt <= '0;
            estado     <= AVALIA;
          end else if (espera_cnt == ULTIMO) begin
            espera_cnt <= '0;
            erro       <= 1'b1;
            estado     <= ERRO;
          end else begin
            espera_cnt <= espera_cnt + 1'b1;
          end
        end
        FIM, ERRO: begin
          pronto <= 1'b1;
          estado <= OCIOSO;
        end
        default: begin
          pronto <= 1'b1;
          estado <= OCIOSO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comandante_contador.sv
// Randomized, model-checked bench for comandante_contador with an emulated counter.
module tb_comandante_contador;

  localparam int L  = 8;
  localparam int TO = 4;

  typedef struct packed {
    logic pronto;
    logic acr;
    logic dec;
    logic conc;
    logic err;
  } exp_t;

  localparam exp_t IDLE = '{pronto: 1'b1, acr: 1'b0, dec: 1'b0, conc: 1'b0, err: 1'b0};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [L-1:0] alvo = '0;
  logic         alvo_valido = 1'b0;
  logic         pronto;
  logic [L-1:0] valor = '0;
  logic         acrescer;
  logic         decrecer;
  logic         concluido;
  logic         erro;

  logic         load_en = 1'b0;
  logic [L-1:0] load_val = '0;
  logic         frozen = 1'b0;
  logic         armed = 1'b0;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int up_cnt, dn_cnt, ev_cyc;
  bit ev_seen, got_conc;
  logic [L-1:0] tgt_model;
  exp_t q[$];

  comandante_contador #(.LARGURA(L), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .alvo        (alvo),
    .alvo_valido (alvo_valido),
    .pronto      (pronto),
    .valor       (valor),
    .acrescer    (acrescer),
    .decrecer    (decrecer),
    .concluido   (concluido),
    .erro        (erro)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Ideal external counter: moves on the edge that ends a pulse cycle unless frozen.
  always @(posedge clk) begin
    if (load_en) valor <= load_val;
    else if (!frozen) begin
      if (acrescer) valor <= valor + 1'b1;
      else if (decrecer) valor <= valor - 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Expected per-cycle outputs after a handshake, from the shortest-path and timing rules.
  task automatic build(input logic [L-1:0] a, input logic [L-1:0] v, input bit frz);
    int   diff, n, last;
    bit   up;
    exp_t e;
    diff = (int'(a) - int'(v) + 256) % 256;
    up   = (diff >= 1) && (diff <= 128);
    n    = (diff == 0) ? 0 : (up ? diff : 256 - diff);
    tgt_model = a;
    if (frz && n > 0) begin
      last = 3 + TO;
      for (int c = 1; c <= last; c++) begin
        e = '0;
        if (c == 2) begin e.acr = up; e.dec = !up; end
        if (c == last) e.err = 1'b1;
        q.push_back(e);
      end
    end else begin
      last = 2 + 3 * n;
      for (int c = 1; c <= last; c++) begin
        e = '0;
        if (c >= 2 && c < last && (c - 2) % 3 == 0) begin e.acr = up; e.dec = !up; end
        if (c == last) e.conc = 1'b1;
        q.push_back(e);
      end
    end
  endtask

  // Compare process: checks every cycle against the model, away from the active edge.
  always @(negedge clk) begin
    if (armed) begin
      exp_t e;
      exp_t got;
      e   = (q.size() > 0) ? q.pop_front() : IDLE;
      got = '{pronto: pronto, acr: acrescer, dec: decrecer, conc: concluido, err: erro};
      check("outputs", 32'(got), 32'(e));
      check("exclusive", 32'(acrescer & decrecer), 32'd0);
      if (acrescer) up_cnt++;
      if (decrecer) dn_cnt++;
      if (concluido || erro) begin
        ev_seen  = 1'b1;
        ev_cyc   = cyc;
        got_conc = concluido;
      end
      if (concluido) check("valor_at_done", 32'(valor), 32'(tgt_model));
      if (rst) q.delete();
      else if (q.size() == 0 && e.pronto && alvo_valido) build(alvo, valor, frozen);
    end
  end

  // Loads the counter, issues one request, then waits (bounded) for concluido or erro.
  task automatic run_req(input logic [L-1:0] v, input logic [L-1:0] a, input bit frz,
                         output int lat, output int ups, output int dns, output bit conc);
    int t0;
    bit done;
    @(posedge clk); #1;
    load_val = v; load_en = 1'b1;
    @(posedge clk); #1;
    load_en = 1'b0;
    frozen = frz; alvo = a; alvo_valido = 1'b1;
    t0 = cyc; up_cnt = 0; dn_cnt = 0; ev_seen = 1'b0; got_conc = 1'b0; ev_cyc = 0;
    done = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      if (ev_seen) begin done = 1'b1; break; end
      alvo_valido = 1'($urandom_range(0, 1));
      alvo = L'($urandom);
    end
    alvo_valido = 1'b0;
    frozen = 1'b0;
    check("request_finished", 32'(done), 32'd1);
    lat = ev_cyc - t0; ups = up_cnt; dns = dn_cnt; conc = got_conc;
  endtask

  initial begin
    int lat, ups, dns, base;
    bit conc;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    armed = 1'b1;
    check("reset_pronto", 32'(pronto), 32'd1);
    check("reset_pulses", 32'({acrescer, decrecer, concluido, erro}), 32'd0);

    run_req(8'h6A, 8'h6D, 1'b0, lat, ups, dns, conc);
    check("up_latency", 32'(lat), 32'd11);
    check("up_acr", 32'(ups), 32'd3);
    check("up_dec", 32'(dns), 32'd0);
    check("up_conc", 32'(conc), 32'd1);

    run_req(8'h6A, 8'h6A, 1'b0, lat, ups, dns, conc);
    check("zero_latency", 32'(lat), 32'd2);
    check("zero_pulses", 32'(ups + dns), 32'd0);
    check("zero_pronto_again", 32'(pronto), 32'd1);

    run_req(8'h02, 8'hFE, 1'b0, lat, ups, dns, conc);
    check("wrap_latency", 32'(lat), 32'd14);
    check("wrap_dec", 32'(dns), 32'd4);
    check("wrap_acr", 32'(ups), 32'd0);
    check("wrap_valor", 32'(valor), 32'hFE);

    run_req(8'h00, 8'h80, 1'b0, lat, ups, dns, conc);
    check("tie_acr", 32'(ups), 32'd128);
    check("tie_dec", 32'(dns), 32'd0);
    check("tie_latency", 32'(lat), 32'd386);

    run_req(8'h10, 8'h12, 1'b1, lat, ups, dns, conc);
    check("timeout_acr", 32'(ups), 32'd1);
    check("timeout_conc", 32'(conc), 32'd0);
    check("timeout_latency", 32'(lat), 32'd7);

    // Reset during the first ESPERA of a five-step request.
    @(posedge clk); #1;
    load_val = 8'h20; load_en = 1'b1;
    @(posedge clk); #1;
    load_en = 1'b0; alvo = 8'h25; alvo_valido = 1'b1;
    up_cnt = 0; dn_cnt = 0; ev_seen = 1'b0;
    @(posedge clk); #1; alvo_valido = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    check("rst_outputs", 32'({acrescer, decrecer, concluido, erro}), 32'd0);
    check("rst_pronto", 32'(pronto), 32'd1);
    base = up_cnt;
    repeat (12) @(posedge clk);
    #1;
    check("rst_prior_pulses", 32'(base), 32'd1);
    check("rst_no_more_pulses", 32'(up_cnt + dn_cnt), 32'(base));
    check("rst_no_event", 32'(ev_seen), 32'd0);

    for (int k = 0; k < 20; k++) begin
      run_req(L'($urandom), L'($urandom), ($urandom_range(0, 5) == 0), lat, ups, dns, conc);
    end

    repeat (3) @(posedge clk);
    #1;
    check("final_queue_empty", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
